instr_mem_responder: RTL
========================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, memory size in 32-bit words (power of two, >=4).
REQ-002 Parameter WAIT_STATES, default 0, request-held cycles before grant (0..15).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port res_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port data_req  input  1  initiator request; held until granted.
REQ-006 Port data_adr  input  32  byte address; word index = data_adr[log2(DEPTH)+1:2], bits [1:0] ignored.
REQ-007 Port data_write_enable  input  1  1 = write, 0 = read; sampled with data_req.
REQ-008 Port data_write  input  32  write data; sampled with data_req.
REQ-009 Port data_gnt  output  1  request accepted this cycle.
REQ-010 Port data_rvalid  output  1  response valid, exactly one cycle per grant.
REQ-011 Port data_read  output  32  response data; meaningful only while data_rvalid=1.

Function
REQ-012 Wait counter (4 bits) SHALL increment each cycle data_req=1 and data_gnt=0, and clear on grant or when data_req=0.
REQ-013 data_gnt SHALL be combinational: data_req=1 and counter==WAIT_STATES; with WAIT_STATES=0, grant in the same cycle as req.
REQ-014 On the grant edge, a write SHALL store data_write at the word index; a read SHALL capture the addressed word into the response register.
REQ-015 data_rvalid SHALL be 1 in the cycle after each grant and 0 otherwise; latency grant->rvalid fixed at 1 cycle.
REQ-016 Write response SHALL return the newly written word on data_read.
REQ-017 A new request SHALL be grantable in the same cycle data_rvalid is high (back-to-back: one grant and one rvalid per cycle sustained when WAIT_STATES=0).
REQ-018 Read granted the cycle after a write to the same word SHALL return the new data (no stale read).
REQ-019 data_read SHALL hold its last value while data_rvalid=0.
REQ-020 Dropping data_req before grant SHALL abort silently: no grant, no memory change, no rvalid.
REQ-021 At most one response outstanding; no response queue.

Reset
REQ-022 res_n=0 SHALL immediately force data_rvalid=0, data_read=0, wait counter=0; data_gnt=0 while res_n=0 regardless of data_req.
REQ-023 Reset mid-operation SHALL discard any pending response; its rvalid never appears.
REQ-024 Memory array contents SHALL NOT be reset; simulation initial contents undefined unless preloaded by bench.

Configuration
REQ-025 Macro MEM_RANGE_ERR_EN SHALL, when defined, add output data_err (1 bit, reset 0), valid with data_rvalid.
REQ-026 With MEM_RANGE_ERR_EN: address with data_adr[31:log2(DEPTH)+2] nonzero SHALL be granted normally, perform no write, return data_read=0 and data_err=1 with rvalid; in-range accesses return data_err=0.
REQ-027 Without MEM_RANGE_ERR_EN: no data_err port; upper address bits ignored, address wraps modulo DEPTH words.

Verification
REQ-028 WAIT_STATES=0, preload word 3=0xDEADBEEF, req read adr 0x0C -> gnt same cycle, rvalid next cycle, data_read=0xDEADBEEF.
REQ-029 WAIT_STATES=2, read held -> gnt on 3rd req cycle, rvalid on 4th; req dropped after 1 cycle -> no gnt, no rvalid.
REQ-030 Write 0x12345678 to adr 0x10 then read 0x10 back-to-back -> two consecutive rvalid cycles, both data_read=0x12345678.
REQ-031 res_n pulled low in cycle between grant and rvalid -> rvalid never asserted, data_read=0, subsequent read completes normally.
REQ-032 MEM_RANGE_ERR_EN, DEPTH=1024, read adr 0x00001000 -> data_err=1, data_read=0; without macro same access returns word 0.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Word-organised instruction/data memory answering a req/gnt/rvalid initiator.
// Defining MEM_RANGE_ERR_EN adds data_err for addresses beyond DEPTH words.
module instr_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        res_n,
   input  logic        data_req,
   input  logic [31:0] data_adr,
   input  logic        data_write_enable,
   input  logic [31:0] data_write,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_read
`ifdef MEM_RANGE_ERR_EN
   ,
   output logic        data_err
`endif
);

   localparam int         AW = $clog2(DEPTH);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic [31:0]   mem_q [DEPTH];
   logic [3:0]    wait_q, wait_d;
   logic          rvalid_q;
   logic [31:0]   read_q, read_d;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          unused_adr_bits;

   assign idx = data_adr[AW+1:2];

`ifdef MEM_RANGE_ERR_EN
   logic err_q;
   assign in_range        = (data_adr[31:AW+2] == '0);
   assign data_err        = err_q;
   assign unused_adr_bits = ^data_adr[1:0];
`else
   // Upper address bits are ignored, so accesses wrap modulo DEPTH words.
   assign in_range        = 1'b1;
   assign unused_adr_bits = ^{data_adr[1:0], data_adr[31:AW+2]};
`endif

   // Handshake: the initiator holds data_req (and address/data) until data_gnt;
   // a transfer happens on the rising edge where data_req && data_gnt, and the
   // response shows data_rvalid for exactly the following cycle.
   assign data_gnt    = res_n & data_req & (wait_q == WS);
   assign data_rvalid = rvalid_q;
   assign data_read   = read_q;

   always_comb begin
      wait_d = wait_q + 4'd1;
      if (!data_req || data_gnt) begin
         wait_d = '0;
      end
   end

   always_comb begin
      read_d = read_q;
      if (data_gnt) begin
         if (!in_range) begin
            read_d = '0;
         end else if (data_write_enable) begin
            read_d = data_write;
         end else begin
            read_d = mem_q[idx];
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wait_q   <= '0;
         rvalid_q <= 1'b0;
         read_q   <= '0;
      end else begin
         wait_q   <= wait_d;
         rvalid_q <= data_gnt;
         read_q   <= read_d;
      end
   end

`ifdef MEM_RANGE_ERR_EN
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         err_q <= 1'b0;
      end else if (data_gnt) begin
         err_q <= ~in_range;
      end
   end
`endif

   // Array contents survive reset.
   always_ff @(posedge clk) begin
      if (data_gnt && data_write_enable && in_range) begin
         mem_q[idx] <= data_write;
      end
   end

endmodule
